fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
Single-clock, fully parametrised FIFO. It succeeds the dual-clock FIFO for paths where producer and consumer share one clock. Over the basic write/read/full/empty set it adds a fill count, programmable almost-full/almost-empty thresholds, write/read acknowledges, and a selectable first-word-fall-through (FWFT) read mode. It sits between same-clock pipeline stages as an elastic buffer.

Parameters:
- DATA_WIDTH, 8, word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop).
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out holds a freshly popped word (FWFT=0 only; in FWFT mode it equals !empty).
- wr_ack  out  1  pulses 1 cycle after an accepted write.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count go to 0; data_out=0; rd_valid=0; wr_ack=0.
  - Flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.
- Acceptance:
  - A write is accepted iff wr_en && !full.
  - A read is accepted iff rd_en && !empty.
  - Both are evaluated on pre-edge state.
- Pointers:
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate register.
- Count update per edge:
  - Write only: +1.
  - Read only: -1.
  - Both accepted, or neither: unchanged.
- Simultaneous requests:
  - When full: the read is accepted and the write is dropped; count becomes DEPTH-1.
  - When empty: the write is accepted and the read is dropped; count becomes 1.
- Flags are decoded combinationally from the registered count, so they reflect state one cycle after the causing edge.
- wr_ack is a registered pulse: 1 on the cycle after each accepted write, otherwise 0.
- FWFT=0:
  - On an accepted read, data_out loads mem[rd_ptr] at that edge and rd_valid=1 for the following cycle.
  - Read latency is 1 cycle.
  - data_out holds its last value when no read is accepted.
  - rd_valid=0 otherwise.
- FWFT=1:
  - data_out continuously presents mem[rd_ptr] whenever !empty; rd_en acknowledges and pops the word.
  - data_out is don't-care while empty.
  - A word written into an empty FIFO appears on data_out in the cycle after the write edge.
- Requests to a full or empty FIFO leave all state unchanged apart from the accepted half.

Optional Feature:
- Macro: FIFO_SYNC_ERR_FLAGS_EN.
- When defined, it adds these ports:
  - err_clr  in  1  clears the sticky error flags.
  - overflow  out  1  sticky; set on the edge where wr_en && full.
  - underflow  out  1  sticky; set on the edge where rd_en && empty.
- Both flags reset to 0.
- If set and err_clr occur in the same cycle, set wins.
- When undefined, these ports and their logic are absent; rejected requests are silently ignored.

Test Plan:
- Reset, then 16 writes of 0x01..0x10 with DATA_WIDTH=8, DEPTH=16, AF_THRESH=12, AE_THRESH=2 -> count steps 1..16; almost_empty falls after the 3rd write; almost_full rises after the 12th; full=1 after the 16th; wr_ack pulses 16 times.
- Full FIFO, 16 reads with FWFT=0 -> data_out 0x01..0x10 in order, each 1 cycle after rd_en with rd_valid=1; empty=1 after the last read.
- FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 the next cycle with rd_en low; a pop returns empty=1.
- Full FIFO, wr_en=1 and rd_en=1 with data_in=0x77 -> one word popped, 0x77 not stored, count=15; overflow=1 when FIFO_SYNC_ERR_FLAGS_EN is defined.
- Empty FIFO, rd_en for 2 cycles -> count stays 0 and data_out unchanged; underflow=1 under the macro; err_clr pulse clears it.
- 8 writes, then rst_n low mid-cycle -> count=0, empty=1 and data_out=0 immediately, without waiting for a clock edge; next write/read returns the new word.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill count, almost-full/empty thresholds,
// write acknowledge and selectable FWFT read mode. Optional sticky error flags: FIFO_SYNC_ERR_FLAGS_EN.
module fifo_sync_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        rd_en,
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    input  logic                        err_clr,
    output logic                        overflow,
    output logic                        underflow,
`endif
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        rd_valid,
    output logic                        wr_ack,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_acc_c, rd_acc_c;

    // Flags decode the registered count, so they lag the causing edge by one cycle.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign wr_ack       = wr_ack_q;

    assign wr_acc_c = wr_en & ~full;
    assign rd_acc_c = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_ack_d = wr_acc_c;
        if (wr_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc_c) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    // Storage array is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) mem_q[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT == 0) begin : g_registered
            logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
            logic                  rd_valid_q, rd_valid_d;

            always_comb begin
                data_out_d = data_out_q;
                rd_valid_d = 1'b0;
                if (rd_acc_c) begin
                    data_out_d = mem_q[rd_ptr_q];
                    rd_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_q <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    data_out_q <= data_out_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign data_out = data_out_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            // Head word is presented directly; forced to zero while empty so reset reads 0.
            assign data_out = empty ? '0 : mem_q[rd_ptr_q];
            assign rd_valid = ~empty;
        end
    endgenerate

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky flags; a new error in the clear cycle wins.
    always_comb begin
        overflow_d  = (wr_en & full)  | (overflow_q  & ~err_clr);
        underflow_d = (rd_en & empty) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
